// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for mem_port_arbiter and its write-channel buffers.
//   - default width constants for the arbiter parameters
//   - state encoding of the port arbitration FSM (S_VGA / S_WR)
//   - rr_next_grant(): round-robin search for the next write channel to grant
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DEF_ADDR_W    = 10;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_NUM_WR    = 2;
    localparam int DEF_MAX_DEFER = 64;

    // Upper bound on write channels; the grant index is therefore 3 bits wide.
    localparam int MAX_WR = 8;

    typedef logic arb_state_t;
    localparam arb_state_t S_VGA = 1'b0;
    localparam arb_state_t S_WR  = 1'b1;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } rr_pick_t;

    // First pending channel at or after 'start', wrapping n-1 -> 0.
    // Two candidates are tracked while scanning downward: the lowest pending
    // channel at/after start ('hi') and the lowest pending channel overall
    // ('lo', used when the search has to wrap).
    function automatic rr_pick_t rr_next_grant(
        input logic [MAX_WR-1:0] pend,
        input logic [2:0]        start,
        input int                n
    );
        rr_pick_t hi;
        rr_pick_t lo;
        hi = '0;
        lo = '0;
        for (int i = MAX_WR - 1; i >= 0; i--) begin
            if (i < n && pend[i]) begin
                lo = '{valid: 1'b1, idx: 3'(i)};
                if (i >= int'(start)) begin
                    hi = '{valid: 1'b1, idx: 3'(i)};
                end
            end
        end
        return hi.valid ? hi : lo;
    endfunction

endpackage

// File: rtl/wr_chan_buf.sv
// ----------------------------------------------------------------------------
// wr_chan_buf
// One-deep pending buffer for a single write channel of mem_port_arbiter.
// A request is latched when the buffer is empty, or when it is being emptied
// (clear_i) on the same edge. A request that finds the buffer full and not
// being emptied is dropped and sets the sticky overflow flag.
//
// Ports:
//   clk_i      system clock
//   rst_ni     synchronous active-low reset
//   req_i      one-cycle write request strobe
//   addr_i     write address presented with req_i
//   data_i     write data presented with req_i
//   clear_i    buffered write has been granted this cycle
//   pending_o  buffer occupied
//   addr_o     buffered address
//   data_o     buffered data
//   ovf_o      sticky overflow (request dropped while busy)
// ----------------------------------------------------------------------------
module wr_chan_buf
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              clear_i,
    output logic              pending_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              ovf_o
);

    logic              pending_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              ovf_q;

    logic accept_w;
    logic drop_w;

    assign accept_w = req_i && (!pending_q || clear_i);
    assign drop_w   = req_i && pending_q && !clear_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pending_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (accept_w) begin
                addr_q    <= addr_i;
                data_q    <= data_i;
                pending_q <= 1'b1;
            end else if (clear_i) begin
                pending_q <= 1'b0;
            end
            if (drop_w) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign pending_o = pending_q;
    assign addr_o    = addr_q;
    assign data_o    = data_q;
    assign ovf_o     = ovf_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port video/text RAM port between the VGA read stream and
// NUM_WR write channels. Each channel has a one-deep buffer (wr_chan_buf);
// buffered writes are granted round-robin, one per cycle, only while the VGA
// fetch window is closed. All RAM-side outputs are registered, so vga_addr_i
// reaches mem_addr_o one cycle later.
//
// Optional feature (macro ARB_STARVE_GUARD_EN): a defer counter counts cycles
// in which a write is pending but VGA holds the port. When it reaches
// MAX_DEFER, a single write is forced through despite vga_active_i.
//
// Ports:
//   clk_i         system clock
//   rst_ni        synchronous active-low reset
//   vga_active_i  VGA needs the port this cycle
//   vga_addr_i    VGA read address
//   wr_req_i      per-channel write request strobe
//   wr_addr_i     flattened write addresses, channel i at [i*ADDR_W +: ADDR_W]
//   wr_data_i     flattened write data, channel i at [i*DATA_W +: DATA_W]
//   wr_busy_o     per-channel buffer occupied
//   wr_done_o     per-channel pulse when its write is on the port
//   wr_ovf_o      per-channel sticky overflow
//   mem_addr_o    registered RAM address
//   mem_wdata_o   registered RAM write data
//   mem_we_o      registered RAM write enable
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_WR    = DEF_NUM_WR,
    parameter int MAX_DEFER = DEF_MAX_DEFER
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     vga_active_i,
    input  logic [ADDR_W-1:0]        vga_addr_i,
    input  logic [NUM_WR-1:0]        wr_req_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    output logic [NUM_WR-1:0]        wr_busy_o,
    output logic [NUM_WR-1:0]        wr_done_o,
    output logic [NUM_WR-1:0]        wr_ovf_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [DATA_W-1:0]        mem_wdata_o,
    output logic                     mem_we_o
);

    if (NUM_WR < 1 || NUM_WR > MAX_WR) begin : g_bad_num_wr
        $error("mem_port_arbiter: NUM_WR must be in 1..8");
    end
    if (MAX_DEFER < 1) begin : g_bad_max_defer
        $error("mem_port_arbiter: MAX_DEFER must be at least 1");
    end

    // ------------------------------------------------------------------
    // Write channel buffers
    // ------------------------------------------------------------------
    logic [NUM_WR-1:0] pend_w;
    logic [NUM_WR-1:0] clear_w;
    logic [NUM_WR-1:0] ovf_w;
    logic [ADDR_W-1:0] buf_addr_w [NUM_WR];
    logic [DATA_W-1:0] buf_data_w [NUM_WR];

    for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_chan
        wr_chan_buf #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_buf (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .req_i     (wr_req_i[gi]),
            .addr_i    (wr_addr_i[gi*ADDR_W +: ADDR_W]),
            .data_i    (wr_data_i[gi*DATA_W +: DATA_W]),
            .clear_i   (clear_w[gi]),
            .pending_o (pend_w[gi]),
            .addr_o    (buf_addr_w[gi]),
            .data_o    (buf_data_w[gi]),
            .ovf_o     (ovf_w[gi])
        );
    end

    assign wr_busy_o = pend_w;
    assign wr_ovf_o  = ovf_w;

    // ------------------------------------------------------------------
    // Round-robin selection
    // ------------------------------------------------------------------
    logic [2:0]        rr_q, rr_d;
    logic [MAX_WR-1:0] pend_ext;
    rr_pick_t          pick;
    logic              any_pend;
    logic              force_w;
    logic              grant_w;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    arb_state_t        state_q, state_d;

    always_comb begin
        pend_ext = '0;
        pend_ext[NUM_WR-1:0] = pend_w;
    end

    assign pick     = rr_next_grant(pend_ext, rr_q, NUM_WR);
    assign any_pend = |pend_w;
    // VGA owns the port unless the starvation guard overrides it.
    assign grant_w  = (state_q == S_WR) && pick.valid && (!vga_active_i || force_w);

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (pick.idx == 3'(i)) begin
                sel_addr = buf_addr_w[i];
                sel_data = buf_data_w[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Starvation guard
    // ------------------------------------------------------------------
`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(MAX_DEFER + 1);

    logic [CNT_W-1:0] defer_q, defer_d;

    // Saturates at MAX_DEFER so the force request stays asserted until the
    // forced grant actually happens (it takes a cycle to enter S_WR).
    always_comb begin
        defer_d = defer_q;
        if (grant_w) begin
            defer_d = '0;
        end else if (any_pend && vga_active_i && defer_q != CNT_W'(MAX_DEFER)) begin
            defer_d = defer_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            defer_q <= '0;
        end else begin
            defer_q <= defer_d;
        end
    end

    assign force_w = (defer_q == CNT_W'(MAX_DEFER));
`else
    assign force_w = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_VGA;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // A cycle in S_WR without a grant (VGA took the port, or nothing is
    // left) is the exit cycle, which also drives mem_we low.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_VGA: if (any_pend && (!vga_active_i || force_w)) state_d = S_WR;
            S_WR:  if (!grant_w) state_d = S_VGA;
            default: state_d = S_VGA;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (next values of the registered RAM-side signals)
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic [NUM_WR-1:0] wr_done_q, wr_done_d;

    always_comb begin
        mem_addr_d  = vga_addr_i;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        wr_done_d   = '0;
        rr_d        = rr_q;
        case (state_q)
            S_WR: begin
                if (grant_w) begin
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_data;
                    mem_we_d    = 1'b1;
                    for (int i = 0; i < NUM_WR; i++) begin
                        if (pick.idx == 3'(i)) wr_done_d[i] = 1'b1;
                    end
                    rr_d = (pick.idx == 3'(NUM_WR - 1)) ? 3'd0 : pick.idx + 3'd1;
                end
            end
            default: ;
        endcase
    end

    // The granted channel's buffer empties on the same edge its write is
    // registered onto the port.
    assign clear_w = wr_done_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            wr_done_q   <= '0;
            rr_q        <= 3'd0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            wr_done_q   <= wr_done_d;
            rr_q        <= rr_d;
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_we_o    = mem_we_q;
    assign wr_done_o   = wr_done_q;

endmodule
